s2mm_stream_framer: RTL and testbench
=====================================

// Module: s2mm_stream_framer
//
// PURPOSE
//   Upstream feeder for the S2MM datamover data channel. Takes an unframed
//   AXI4-Stream and cuts it into packets of exactly BTT_BYTES. Drives TLAST on
//   the final beat of each packet, so every S2MM command completes on a packet
//   boundary. A 2-entry skid buffer gives registered ready/valid on both sides.
//   Counts emitted packets and source overrun cycles for debug.
//
// PARAMETERS
//   DATA_WIDTH  64    stream data width in bits; multiple of 8
//   BTT_BYTES   4096  bytes per packet; must equal the S2MM command BTT
//   BEATS       BTT_BYTES/(DATA_WIDTH/8)  derived localparam, >= 2 (512 at defaults)
//
// PORTS
//   clk            in   1           stream clock
//   aresetn        in   1           async active-low reset; sync deassert is done outside this block
//   enable         in   1           run request; sampled only at packet boundaries
//   s_axis_tdata   in   DATA_WIDTH  raw input data
//   s_axis_tvalid  in   1           raw input valid
//   s_axis_tready  out  1           registered ready to source
//   m_axis_tdata   out  DATA_WIDTH  framed data to S2MM
//   m_axis_tvalid  out  1           framed valid
//   m_axis_tlast   out  1           high on beat BEATS-1 of each packet
//   m_axis_tkeep   out  DATA_WIDTH/8  constant all ones
//   m_axis_tready  in   1           S2MM data ready
//   pkt_count      out  32          packets fully emitted (TLAST handshakes), wraps
//   overrun_count  out  32          RUN cycles with s_tvalid=1 and s_tready=0; saturates at 2^32-1
//   busy           out  1           high in RUN state
//
// BEHAVIOUR
//   Reset (aresetn=0, async): state=IDLE, beat_cnt=0, skid and output regs empty.
//     All outputs are 0, except m_axis_tkeep, which is all ones.
//   FSM:
//     IDLE -> RUN when enable=1. s_axis_tready=0 while in IDLE.
//     RUN: accepted beats are numbered by beat_cnt, 0..BEATS-1.
//     When beat BEATS-1 is accepted, beat_cnt wraps to 0. On that same edge:
//       - stay in RUN if enable=1;
//       - otherwise go to IDLE.
//     enable=0 mid-packet has no effect until the packet's last beat is accepted.
//     No partial packets are ever produced.
//   Input accept: s_axis_tvalid & s_axis_tready.
//     The tlast bit is computed at accept time as (beat_cnt==BEATS-1).
//     It travels with the data through the buffer.
//   Skid buffer, two registers (out_reg, skid_reg):
//     - s_axis_tready <= (state_next==RUN) & ~skid_valid_next. Registered, no
//       combinational path from m_axis_tready.
//     - Accept when out_reg empty, or out_reg draining (m_axis_tready=1):
//       beat loads out_reg.
//     - Accept when out_reg full and stalled: beat loads skid_reg.
//     - When out_reg drains and skid_reg is valid: skid_reg moves into out_reg.
//   Latency: a beat accepted at edge N is on m_axis at cycle N+1 if out_reg was empty.
//   Throughput: 1 beat/cycle with m_axis_tready held high.
//   Ordering: beats are never dropped, duplicated or reordered.
//   Output rule: once m_axis_tvalid=1, data and last are held until m_axis_tready=1.
//   Drain: the buffer keeps draining in IDLE after the last packet. busy=0 in IDLE.
//   pkt_count increments on m_axis_tvalid & m_axis_tready & m_axis_tlast.
//   overrun_count counts only in RUN state.
//   Reset mid-packet: buffered beats are discarded; beat_cnt restarts at 0.
//     The next TLAST is on the BEATS-th beat accepted after reset.
//   Both counters clear only on reset.
//
// TESTING
//   1 Reset: hold aresetn=0 with s_tvalid=1, enable=1 -> s_tready=0, m_tvalid=0,
//     counters 0. Release -> IDLE, then RUN one cycle later; first accept follows.
//   2 Stream, defaults: counting data 0..1023, m_tready=1, enable=1
//     -> TLAST only on data 511 and 1023, pkt_count=2, data in order.
//   3 Backpressure: random 50% m_tready over 3 packets -> output equals input in
//     order, TLAST every 512th beat, no X on m_tdata while m_tvalid=1.
//   4 Disable mid-packet: drop enable after beat 100 -> beats 101..511 still
//     accepted, TLAST on 511, then s_tready=0 and busy=0; beat 512 never accepted.
//   5 Async reset at beat 200 -> outputs clear with no clock edge.
//     After release and 512 further beats, TLAST is on the 512th; pkt_count counts only that packet.
//   6 Overrun: m_tready=0 for 10 cycles with s_tvalid=1 in RUN -> 2 beats
//     accepted (out_reg + skid_reg), overrun_count=8.

Source files
------------

// File: rtl/s2mm_stream_framer.sv
// s2mm_stream_framer
//   Cuts an unframed AXI4-Stream into packets of exactly BTT_BYTES bytes and
//   drives TLAST on the final beat of each packet, so that every S2MM command
//   completes on a packet boundary. A two-register skid buffer registers
//   ready/valid on both sides. It also keeps debug counters for emitted
//   packets and source overrun cycles.
//
// Ports
//   clk, aresetn    stream clock, async active-low reset
//   enable          run request, sampled only at packet boundaries
//   s_axis_*        raw input stream (tdata, tvalid, tready)
//   m_axis_*        framed output stream (tdata, tvalid, tlast, tkeep, tready)
//   pkt_count       count of TLAST handshakes, wraps
//   overrun_count   RUN cycles with s_tvalid=1 and s_tready=0, saturates
//   busy            high while in the RUN state
module s2mm_stream_framer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BTT_BYTES  = 4096
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  input  logic                    m_axis_tready,
  output logic [31:0]             pkt_count,
  output logic [31:0]             overrun_count,
  output logic                    busy
);

  localparam int unsigned BEATS = BTT_BYTES / (DATA_WIDTH / 8);
  localparam int unsigned CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LastBeat = CW'(BEATS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                  r_state, w_state_next;
  logic [CW-1:0]           r_beat_cnt, w_beat_cnt_next;
  logic                    r_s_tready, w_s_tready_next;

  logic                    r_out_valid, w_out_valid_next;
  logic [DATA_WIDTH-1:0]   r_out_data, w_out_data_next;
  logic                    r_out_last, w_out_last_next;
  logic                    r_skid_valid, w_skid_valid_next;
  logic [DATA_WIDTH-1:0]   r_skid_data, w_skid_data_next;
  logic                    r_skid_last, w_skid_last_next;

  logic [31:0]             r_pkt_cnt;
  logic [31:0]             r_ovr_cnt;

  logic                    w_accept;
  logic                    w_in_last;
  logic                    w_out_free;
  logic                    w_out_hs;

  assign w_accept   = s_axis_tvalid & r_s_tready;
  assign w_in_last  = (r_beat_cnt == LastBeat);
  // out_reg can take a new beat if empty or handing its beat over this cycle
  assign w_out_free = ~r_out_valid | m_axis_tready;
  assign w_out_hs   = r_out_valid & m_axis_tready;

  // Framing FSM: leaving RUN is only possible on the edge that accepts the
  // last beat of a packet, so partial packets can never be produced.
  always_comb begin
    w_state_next    = r_state;
    w_beat_cnt_next = r_beat_cnt;
    if (w_accept) begin
      w_beat_cnt_next = w_in_last ? '0 : r_beat_cnt + CW'(1);
    end
    unique case (r_state)
      StIdle: begin
        if (enable) w_state_next = StRun;
      end
      StRun: begin
        if (w_accept && w_in_last && !enable) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Skid buffer next state. skid_reg only fills when out_reg is stalled.
  always_comb begin
    w_out_valid_next  = r_out_valid;
    w_out_data_next   = r_out_data;
    w_out_last_next   = r_out_last;
    w_skid_valid_next = r_skid_valid;
    w_skid_data_next  = r_skid_data;
    w_skid_last_next  = r_skid_last;
    if (w_out_free) begin
      if (r_skid_valid) begin
        w_out_valid_next = 1'b1;
        w_out_data_next  = r_skid_data;
        w_out_last_next  = r_skid_last;
        if (w_accept) begin
          w_skid_data_next = s_axis_tdata;
          w_skid_last_next = w_in_last;
        end else begin
          w_skid_valid_next = 1'b0;
        end
      end else if (w_accept) begin
        w_out_valid_next = 1'b1;
        w_out_data_next  = s_axis_tdata;
        w_out_last_next  = w_in_last;
      end else begin
        w_out_valid_next = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_valid_next = 1'b1;
      w_skid_data_next  = s_axis_tdata;
      w_skid_last_next  = w_in_last;
    end
    // Ready looks only at next-state values, so m_axis_tready never reaches
    // s_axis_tready combinationally.
    w_s_tready_next = (w_state_next == StRun) & ~w_skid_valid_next;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= StIdle;
      r_beat_cnt   <= '0;
      r_s_tready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_last  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_beat_cnt   <= w_beat_cnt_next;
      r_s_tready   <= w_s_tready_next;
      r_out_valid  <= w_out_valid_next;
      r_out_data   <= w_out_data_next;
      r_out_last   <= w_out_last_next;
      r_skid_valid <= w_skid_valid_next;
      r_skid_data  <= w_skid_data_next;
      r_skid_last  <= w_skid_last_next;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_pkt_cnt <= '0;
      r_ovr_cnt <= '0;
    end else begin
      if (w_out_hs && r_out_last) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if ((r_state == StRun) && s_axis_tvalid && !r_s_tready && (r_ovr_cnt != '1)) begin
        r_ovr_cnt <= r_ovr_cnt + 32'd1;
      end
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tlast  = r_out_last;
  assign m_axis_tkeep  = '1;
  assign pkt_count     = r_pkt_cnt;
  assign overrun_count = r_ovr_cnt;
  assign busy          = (r_state == StRun);

endmodule

// File: tb/tb_s2mm_stream_framer.sv
// Testbench for s2mm_stream_framer: random/counting stimulus, scoreboard queue
// filled at accept time from a packet-position model, drained by a monitor.
module tb_s2mm_stream_framer;

  localparam int DW    = 64;
  localparam int BTT   = 4096;
  localparam int BEATS = BTT / (DW / 8);

  logic          clk = 1'b0;
  logic          aresetn;
  logic          enable;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic [DW/8-1:0] m_tkeep;
  logic          m_tready;
  logic [31:0]   pkt_count;
  logic [31:0]   overrun_count;
  logic          busy;

  s2mm_stream_framer #(
    .DATA_WIDTH(DW),
    .BTT_BYTES (BTT)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .enable       (enable),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tready(m_tready),
    .pkt_count    (pkt_count),
    .overrun_count(overrun_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          acc_n   = 0;     // beats accepted since the last reset
  logic [DW-1:0] next_data = '0;
  bit          rand_data = 1'b0;
  logic [DW:0] sb_q[$];         // {last, data}

  logic        mon_prev_stall = 1'b0;
  logic [DW:0] mon_prev_beat  = '0;
  logic [DW:0] mon_exp;

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; a beat seen accepted is pushed with its expected
  // TLAST, i.e. whether it is the final beat of a BEATS-long packet.
  task automatic cycle(input logic sv, input logic mr);
    @(negedge clk);
    s_tvalid = sv;
    s_tdata  = next_data;
    m_tready = mr;
    #1;
    if (aresetn && s_tvalid && s_tready) begin
      sb_q.push_back({((acc_n % BEATS) == BEATS - 1), next_data});
      acc_n++;
      next_data = rand_data ? {$urandom, $urandom} : next_data + 1;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    do begin
      cycle(1'b0, 1'b1);
      g++;
    end while ((sb_q.size() != 0 || m_tvalid) && g < 100);
    check("drain_empty", {63'd0, m_tvalid, 1'(sb_q.size() != 0)}, '0);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!aresetn) begin
        mon_prev_stall = 1'b0;
      end else begin
        if (mon_prev_stall) check("hold_stalled", {m_tlast, m_tdata}, mon_prev_beat);
        if (m_tvalid) check("x_on_tdata", {64'd0, $isunknown(m_tdata)}, '0);
        if (m_tvalid && m_tready) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h, expected no beat", {m_tlast, m_tdata});
          end else begin
            mon_exp = sb_q.pop_front();
            check("beat", {m_tlast, m_tdata}, mon_exp);
          end
        end
        mon_prev_stall = m_tvalid && !m_tready;
        mon_prev_beat  = {m_tlast, m_tdata};
      end
    end
  end

  initial begin
    int cyc;
    int base;
    logic [31:0] ovr0;

    // 1: reset with source asserting valid and enable high
    aresetn  = 1'b0;
    enable   = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = '0;
    m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_s_tready", {64'd0, s_tready}, '0);
    check("rst_m_tvalid", {64'd0, m_tvalid}, '0);
    check("rst_m_tlast", {64'd0, m_tlast}, '0);
    check("rst_m_tdata", {1'b0, m_tdata}, '0);
    check("rst_pkt", {33'd0, pkt_count}, '0);
    check("rst_ovr", {33'd0, overrun_count}, '0);
    check("rst_busy", {64'd0, busy}, '0);
    check("rst_tkeep", {57'd0, m_tkeep}, 65'hff);
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    check("rel_idle_busy", {64'd0, busy}, '0);
    check("rel_idle_tready", {64'd0, s_tready}, '0);
    @(posedge clk);
    #1;
    check("rel_run_busy", {64'd0, busy}, 65'd1);
    check("rel_run_tready", {64'd0, s_tready}, 65'd1);

    // 2: counting data, full throughput
    cyc = 0;
    while (acc_n < 2 * BEATS && cyc < 3000) begin
      cycle(1'b1, 1'b1);
      cyc++;
    end
    check("t2_cycles", 65'(cyc), 65'(2 * BEATS));
    drain();
    check("t2_pkt", {33'd0, pkt_count}, 65'd2);
    check("t2_ovr", {33'd0, overrun_count}, '0);

    // 3: random data, random source valid and sink backpressure
    rand_data = 1'b1;
    next_data = {$urandom, $urandom};
    base = acc_n;
    cyc  = 0;
    while (acc_n < base + 3 * BEATS && cyc < 20000) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      cyc++;
    end
    check("t3_accepted", 65'(acc_n - base), 65'(3 * BEATS));
    drain();
    check("t3_pkt", {33'd0, pkt_count}, 65'(acc_n / BEATS));

    // 4: drop enable mid-packet
    ovr0 = overrun_count;
    base = acc_n;
    cyc  = 0;
    while (acc_n < base + 101 && cyc < 1000) begin
      cycle(1'b1, 1'b1);
      cyc++;
    end
    enable = 1'b0;
    while (acc_n < base + BEATS && cyc < 3000) begin
      cycle(1'b1, 1'b1);
      cyc++;
    end
    repeat (20) cycle(1'b1, 1'b1);
    check("t4_accepted", 65'(acc_n - base), 65'(BEATS));
    check("t4_busy", {64'd0, busy}, '0);
    check("t4_tready", {64'd0, s_tready}, '0);
    check("t4_ovr_idle", {33'd0, overrun_count}, {33'd0, ovr0});
    drain();
    check("t4_pkt", {33'd0, pkt_count}, 65'(acc_n / BEATS));

    // 5: async reset in the middle of a packet
    enable = 1'b1;
    base = acc_n;
    cyc  = 0;
    while (acc_n < base + 200 && cyc < 3000) begin
      cycle(1'b1, 1'($urandom_range(0, 1)));
      cyc++;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    #3;
    aresetn = 1'b0;
    #1;
    check("t5_m_tvalid", {64'd0, m_tvalid}, '0);
    check("t5_s_tready", {64'd0, s_tready}, '0);
    check("t5_busy", {64'd0, busy}, '0);
    check("t5_pkt", {33'd0, pkt_count}, '0);
    sb_q.delete();
    acc_n = 0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    cyc = 0;
    while (acc_n < BEATS && cyc < 2000) begin
      cycle(1'b1, 1'b1);
      cyc++;
    end
    check("t5_accepted", 65'(acc_n), 65'(BEATS));
    drain();
    check("t5_pkt_after", {33'd0, pkt_count}, 65'd1);

    // 6: sink stalled for 10 cycles while the source keeps offering
    base = acc_n;
    repeat (10) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("t6_accepted", 65'(acc_n - base), 65'd2);
    check("t6_ovr", {33'd0, overrun_count}, 65'd8);
    check("t6_tready", {64'd0, s_tready}, '0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
